// File: rtl/swipt_pkg.sv
// Shared constants, default duty levels and FSM encoding for the SWIPT data modulator.
package swipt_pkg;

    localparam int unsigned CLK_HZ     = 100_000_000;
    localparam int unsigned FREQ_W     = 20;
    localparam int unsigned L_W        = 12;
    localparam int unsigned PERIOD_W   = 13;
    localparam int unsigned PERIOD_MAX = 8191;
    localparam int unsigned QUO_W      = 28;
    localparam int unsigned REM_W      = 21;
    localparam int unsigned DIV_CNT_W  = 5;
    localparam int unsigned BIT_CNT_W  = 8;
    localparam int unsigned IDX_W      = 3;

    // Default per-mille pulse lengths.
    localparam int unsigned L_IDLE_DEF = 480;
    localparam int unsigned L_ONE_DEF  = 480;
    localparam int unsigned L_ZERO_DEF = 200;

    typedef enum logic [2:0] {
        IDLE,
        DIV,
        START,
        DATA,
        STOP
    } swipt_state_e;

endpackage

// File: rtl/swipt_period_div.sv
// Sequential restoring divider: quotient = CLK_HZ / divisor, one quotient bit per clk.
// Ports:
//   clk, nrst  clock, synchronous active-low reset
//   start      load divisor and begin a 28-cycle divide
//   divisor    20-bit divisor (sampled on start)
//   done       one-cycle pulse when quotient is valid
//   quotient   28-bit quotient
module swipt_period_div #(
    parameter int unsigned CLK_HZ = swipt_pkg::CLK_HZ
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start,
    input  logic [swipt_pkg::FREQ_W-1:0] divisor,
    output logic                         done,
    output logic [swipt_pkg::QUO_W-1:0]  quotient
);
    import swipt_pkg::*;

    logic [REM_W-1:0]     rem_q, rem_d;
    logic [QUO_W-1:0]     quo_q, quo_d;
    logic [FREQ_W-1:0]    dvs_q, dvs_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [REM_W:0]       trial_c;

    // Dividend bits shift out of the top of quo_q while quotient bits shift in at the bottom.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        trial_c = {rem_q, quo_q[QUO_W-1]};
        if (start) begin
            rem_d = '0;
            quo_d = QUO_W'(CLK_HZ);
            dvs_d = divisor;
            cnt_d = DIV_CNT_W'(QUO_W);
        end else if (cnt_q != '0) begin
            if (trial_c >= (REM_W+1)'(dvs_q)) begin
                rem_d = REM_W'(trial_c - (REM_W+1)'(dvs_q));
                quo_d = {quo_q[QUO_W-2:0], 1'b1};
            end else begin
                rem_d = REM_W'(trial_c);
                quo_d = {quo_q[QUO_W-2:0], 1'b0};
            end
            cnt_d  = cnt_q - DIV_CNT_W'(1);
            done_d = (cnt_q == DIV_CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/swipt_data_mod.sv
// SWIPT data modulator: turns bytes into a UART-like frame of per-mille pulse lengths,
// with bit time counted in whole SWIPT periods (period = CLK_HZ / freq).
// Ports:
//   clk, nrst  clock, synchronous active-low reset
//   freq_in    requested SWIPT frequency (Hz); 0 is never latched
//   tx_data    byte to send; tx_valid/tx_ready handshake
//   freq_out   latched frequency for the driver
//   l_out      per-mille pulse length for the driver
//   busy       frame in progress
//   period     clk cycles per SWIPT period, saturated
module swipt_data_mod #(
    parameter int unsigned CLK_HZ         = swipt_pkg::CLK_HZ,
    parameter int unsigned CYCLES_PER_BIT = 8,
    parameter int unsigned L_IDLE         = swipt_pkg::L_IDLE_DEF,
    parameter int unsigned L_ONE          = swipt_pkg::L_ONE_DEF,
    parameter int unsigned L_ZERO         = swipt_pkg::L_ZERO_DEF
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic [swipt_pkg::FREQ_W-1:0]   freq_in,
    input  logic [7:0]                     tx_data,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    output logic [swipt_pkg::FREQ_W-1:0]   freq_out,
    output logic [swipt_pkg::L_W-1:0]      l_out,
    output logic                           busy,
    output logic [swipt_pkg::PERIOD_W-1:0] period
);
    import swipt_pkg::*;

    swipt_state_e         state_q, state_d;
    logic [FREQ_W-1:0]    freq_out_q, freq_out_d;
    logic [L_W-1:0]       l_out_q, l_out_d;
    logic                 busy_q, busy_d;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic [7:0]           shift_q, shift_d;
    logic [PERIOD_W-1:0]  period_cnt_q, period_cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic                 div_start_c;
    logic                 div_done;
    logic [QUO_W-1:0]     div_quo;
    logic                 freq_change_c;
    logic                 bit_end_c;
    logic                 tx_ready_c;
    logic [PERIOD_W-1:0]  period_sat_c;

    swipt_period_div #(
        .CLK_HZ (CLK_HZ)
    ) u_div (
        .clk      (clk),
        .nrst     (nrst),
        .start    (div_start_c),
        .divisor  (freq_in),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign period_sat_c = (div_quo > QUO_W'(PERIOD_MAX)) ? PERIOD_W'(PERIOD_MAX)
                                                         : PERIOD_W'(div_quo);

    // Next-state, handshake and output levels.
    always_comb begin
        state_d      = state_q;
        freq_out_d   = freq_out_q;
        l_out_d      = l_out_q;
        busy_d       = busy_q;
        period_d     = period_q;
        shift_d      = shift_q;
        period_cnt_d = period_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        idx_d        = idx_q;
        div_start_c  = 1'b0;

        freq_change_c = (freq_in != freq_out_q) && (freq_in != '0);
        bit_end_c     = (period_cnt_q == '0) && (bit_cnt_q == '0);
        // Ready is combinational on freq_in so a pending re-divide blocks acceptance in the same cycle.
        tx_ready_c    = (state_q == IDLE) && (period_q != '0) && !freq_change_c;

        // Bit timer: period_cnt wraps every SWIPT period, bit_cnt counts periods per bit.
        if (state_q == START || state_q == DATA || state_q == STOP) begin
            if (period_cnt_q == '0) begin
                period_cnt_d = period_q - PERIOD_W'(1);
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = BIT_CNT_W'(CYCLES_PER_BIT - 1);
                end else begin
                    bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                end
            end else begin
                period_cnt_d = period_cnt_q - PERIOD_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (freq_change_c) begin
                    freq_out_d  = freq_in;
                    div_start_c = 1'b1;
                    state_d     = DIV;
                end else if (tx_ready_c && tx_valid) begin
                    shift_d      = tx_data;
                    busy_d       = 1'b1;
                    l_out_d      = L_W'(L_ZERO);
                    period_cnt_d = period_q - PERIOD_W'(1);
                    bit_cnt_d    = BIT_CNT_W'(CYCLES_PER_BIT - 1);
                    state_d      = START;
                end
            end
            DIV: begin
                if (div_done) begin
                    period_d = period_sat_c;
                    state_d  = IDLE;
                end
            end
            START: begin
                if (bit_end_c) begin
                    idx_d   = '1;
                    l_out_d = shift_q[7] ? L_W'(L_ONE) : L_W'(L_ZERO);
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    if (idx_q == '0) begin
                        l_out_d = L_W'(L_ONE);
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        l_out_d = shift_q[6] ? L_W'(L_ONE) : L_W'(L_ZERO);
                    end
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    l_out_d = L_W'(L_IDLE);
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= IDLE;
            freq_out_q   <= '0;
            l_out_q      <= L_W'(L_IDLE);
            busy_q       <= 1'b0;
            period_q     <= '0;
            shift_q      <= '0;
            period_cnt_q <= '0;
            bit_cnt_q    <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            freq_out_q   <= freq_out_d;
            l_out_q      <= l_out_d;
            busy_q       <= busy_d;
            period_q     <= period_d;
            shift_q      <= shift_d;
            period_cnt_q <= period_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            idx_q        <= idx_d;
        end
    end

    assign tx_ready = tx_ready_c;
    assign freq_out = freq_out_q;
    assign l_out    = l_out_q;
    assign busy     = busy_q;
    assign period   = period_q;

endmodule

// File: tb/tb_swipt_data_mod.sv
// Directed bench for swipt_data_mod. CYCLES_PER_BIT is 2, so one bit is 2*period clks.
`timescale 1ns/1ps
module tb_swipt_data_mod;

    localparam int unsigned CPB      = 2;
    localparam int          BIT_1K   = 2000;  // bit length at period 1000
    localparam int          BIT_100  = 200;   // bit length at period 100

    logic        clk = 1'b0;
    logic        nrst;
    logic [19:0] freq_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [19:0] freq_out;
    logic [11:0] l_out;
    logic        busy;
    logic [12:0] period;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    swipt_data_mod #(
        .CLK_HZ         (100_000_000),
        .CYCLES_PER_BIT (CPB),
        .L_IDLE         (480),
        .L_ONE          (480),
        .L_ZERO         (200)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .freq_in  (freq_in),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .freq_out (freq_out),
        .l_out    (l_out),
        .busy     (busy),
        .period   (period)
    );

    task automatic test_reset();
        nrst     = 1'b0;
        freq_in  = 20'd0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready got=%0b want=0", tx_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (l_out !== 12'd480) begin bad++; $display("FAIL reset_l_out got=%0d want=480", l_out); end
        total++; if (freq_out !== 20'd0) begin bad++; $display("FAIL reset_freq_out got=%0d want=0", freq_out); end
        total++; if (period !== 13'd0) begin bad++; $display("FAIL reset_period got=%0d want=0", period); end
    endtask

    task automatic test_zero_freq();
        int nbad;
        nbad    = 0;
        nrst    = 1'b1;
        freq_in = 20'd0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_ready !== 1'b0 || l_out !== 12'd480 || busy !== 1'b0) nbad++;
        end
        total++; if (nbad != 0) begin bad++; $display("FAIL zero_freq_idle bad_cycles=%0d want=0", nbad); end
        total++; if (freq_out !== 20'd0) begin bad++; $display("FAIL zero_freq_latched got=%0d want=0", freq_out); end
        total++; if (period !== 13'd0) begin bad++; $display("FAIL zero_freq_period got=%0d want=0", period); end
    endtask

    task automatic test_div();
        int n;
        freq_in = 20'd100_000;
        @(negedge clk);
        n = 1;
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL div_ready_low got=%0b want=0", tx_ready); end
        while (period === 13'd0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++; if (n < 29 || n > 30) begin bad++; $display("FAIL div_latency got=%0d want=29..30", n); end
        total++; if (period !== 13'd1000) begin bad++; $display("FAIL div_period got=%0d want=1000", period); end
        total++; if (freq_out !== 20'd100_000) begin bad++; $display("FAIL div_freq_out got=%0d want=100000", freq_out); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL div_ready_after got=%0b want=1", tx_ready); end
        total++; if (l_out !== 12'd480) begin bad++; $display("FAIL div_l_out got=%0d want=480", l_out); end
    endtask

    task automatic test_frame();
        logic [11:0] exp_lv [10];
        int          lvl_bad [10];
        logic [11:0] lvl_got [10];
        int          busy_bad;
        int          k;
        exp_lv   = '{12'd200, 12'd480, 12'd200, 12'd480, 12'd200,
                     12'd200, 12'd480, 12'd200, 12'd480, 12'd480};
        busy_bad = 0;
        foreach (lvl_bad[i]) begin lvl_bad[i] = 0; lvl_got[i] = 12'd0; end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL frame_ready_pre got=%0b want=1", tx_ready); end
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL frame_ready_accept got=%0b want=0", tx_ready); end
        for (int c = 1; c <= 10 * BIT_1K; c++) begin
            if (c > 1) @(negedge clk);
            k = (c - 1) / BIT_1K;
            if (l_out !== exp_lv[k]) begin lvl_bad[k]++; lvl_got[k] = l_out; end
            if (busy !== 1'b1) busy_bad++;
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (lvl_bad[i] != 0) begin
                bad++;
                $display("FAIL frame_a5_bit%0d got=%0d want=%0d bad_cycles=%0d", i, lvl_got[i], exp_lv[i], lvl_bad[i]);
            end
        end
        total++; if (busy_bad != 0) begin bad++; $display("FAIL frame_busy bad_cycles=%0d want=0", busy_bad); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame_end_busy got=%0b want=0", busy); end
        total++; if (l_out !== 12'd480) begin bad++; $display("FAIL frame_end_l_out got=%0d want=480", l_out); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL frame_end_ready got=%0b want=1", tx_ready); end
    endtask

    task automatic test_saturate();
        int n;
        freq_in = 20'd10_000;
        n = 0;
        while (period !== 13'd8191 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++; if (period !== 13'd8191) begin bad++; $display("FAIL sat_period got=%0d want=8191", period); end
        total++; if (freq_out !== 20'd10_000) begin bad++; $display("FAIL sat_freq_out got=%0d want=10000", freq_out); end
        freq_in = 20'd100_000;
        n = 0;
        while (period !== 13'd1000 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++; if (n < 29 || n > 30) begin bad++; $display("FAIL sat_restore_latency got=%0d want=29..30", n); end
        total++; if (period !== 13'd1000) begin bad++; $display("FAIL sat_restore_period got=%0d want=1000", period); end
    endtask

    task automatic test_freq_change();
        int busy_bad;
        int n;
        busy_bad = 0;
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL fchg_ready_pre got=%0b want=1", tx_ready); end
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int c = 1; c <= 10 * BIT_1K; c++) begin
            if (c > 1) @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (c == 5000) freq_in = 20'd200_000;
            if (c == 14000) begin
                total++; if (l_out !== 12'd480) begin bad++; $display("FAIL fchg_bit6_end got=%0d want=480", l_out); end
            end
            if (c == 14001) begin
                total++; if (l_out !== 12'd200) begin bad++; $display("FAIL fchg_bit7_start got=%0d want=200", l_out); end
            end
            if (c == 18000) begin
                total++; if (l_out !== 12'd200) begin bad++; $display("FAIL fchg_bit8_end got=%0d want=200", l_out); end
            end
            if (c == 18001) begin
                total++; if (l_out !== 12'd480) begin bad++; $display("FAIL fchg_stop_start got=%0d want=480", l_out); end
            end
            if (c == 20000) begin
                total++; if (freq_out !== 20'd100_000) begin bad++; $display("FAIL fchg_freq_held got=%0d want=100000", freq_out); end
            end
        end
        total++; if (busy_bad != 0) begin bad++; $display("FAIL fchg_busy bad_cycles=%0d want=0", busy_bad); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fchg_end_busy got=%0b want=0", busy); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL fchg_end_ready got=%0b want=0", tx_ready); end
        n = 0;
        while (period !== 13'd500 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++; if (n < 29 || n > 30) begin bad++; $display("FAIL fchg_div_latency got=%0d want=29..30", n); end
        total++; if (period !== 13'd500) begin bad++; $display("FAIL fchg_period got=%0d want=500", period); end
        total++; if (freq_out !== 20'd200_000) begin bad++; $display("FAIL fchg_freq_out got=%0d want=200000", freq_out); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp1 [10];
        logic [11:0] exp2 [10];
        int          nbad;
        int          n;
        exp1 = '{12'd200, 12'd480, 12'd200, 12'd200, 12'd200,
                 12'd200, 12'd200, 12'd200, 12'd480, 12'd480};
        exp2 = '{12'd200, 12'd200, 12'd480, 12'd480, 12'd480,
                 12'd480, 12'd480, 12'd480, 12'd200, 12'd480};
        freq_in = 20'd1_000_000;
        n = 0;
        while (period !== 13'd100 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++; if (period !== 13'd100) begin bad++; $display("FAIL b2b_period got=%0d want=100", period); end
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h7E;
        nbad = 0;
        for (int c = 1; c <= 10 * BIT_100; c++) begin
            if (c > 1) @(negedge clk);
            if (busy !== 1'b1 || tx_ready !== 1'b0) nbad++;
            if ((c - 1) % BIT_100 == BIT_100 / 2) begin
                total++;
                if (l_out !== exp1[(c - 1) / BIT_100]) begin
                    bad++;
                    $display("FAIL b2b_f1_bit%0d got=%0d want=%0d", (c - 1) / BIT_100, l_out, exp1[(c - 1) / BIT_100]);
                end
            end
        end
        total++; if (nbad != 0) begin bad++; $display("FAIL b2b_f1_busy bad_cycles=%0d want=0", nbad); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_gap_busy got=%0b want=0", busy); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL b2b_gap_ready got=%0b want=1", tx_ready); end
        @(negedge clk);
        tx_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_f2_start_busy got=%0b want=1", busy); end
        nbad = 0;
        for (int c = 1; c <= 10 * BIT_100; c++) begin
            if (c > 1) @(negedge clk);
            if (busy !== 1'b1) nbad++;
            if ((c - 1) % BIT_100 == BIT_100 / 2) begin
                total++;
                if (l_out !== exp2[(c - 1) / BIT_100]) begin
                    bad++;
                    $display("FAIL b2b_f2_bit%0d got=%0d want=%0d", (c - 1) / BIT_100, l_out, exp2[(c - 1) / BIT_100]);
                end
            end
        end
        total++; if (nbad != 0) begin bad++; $display("FAIL b2b_f2_busy bad_cycles=%0d want=0", nbad); end
        nbad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || l_out !== 12'd480) nbad++;
        end
        total++; if (nbad != 0) begin bad++; $display("FAIL b2b_no_third_frame bad_cycles=%0d want=0", nbad); end
    endtask

    task automatic test_reset_mid_frame();
        int nbad;
        int n;
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (1099) @(negedge clk);
        total++; if (l_out !== 12'd200 || busy !== 1'b1) begin
            bad++; $display("FAIL rst_mid_pre l_out=%0d busy=%0b want=200,1", l_out, busy);
        end
        nrst = 1'b0;
        @(negedge clk);
        total++; if (l_out !== 12'd480) begin bad++; $display("FAIL rst_mid_l_out got=%0d want=480", l_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b want=0", busy); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%0b want=0", tx_ready); end
        total++; if (period !== 13'd0) begin bad++; $display("FAIL rst_mid_period got=%0d want=0", period); end
        total++; if (freq_out !== 20'd0) begin bad++; $display("FAIL rst_mid_freq_out got=%0d want=0", freq_out); end
        nrst = 1'b1;
        nbad = 0;
        n = 0;
        while (period === 13'd0 && n < 40) begin
            @(negedge clk);
            n++;
            if (busy !== 1'b0 || l_out !== 12'd480) nbad++;
        end
        total++; if (n < 29 || n > 30) begin bad++; $display("FAIL rst_redo_latency got=%0d want=29..30", n); end
        total++; if (period !== 13'd100) begin bad++; $display("FAIL rst_redo_period got=%0d want=100", period); end
        total++; if (nbad != 0) begin bad++; $display("FAIL rst_no_resume bad_cycles=%0d want=0", nbad); end
    endtask

    initial begin
        test_reset();
        test_zero_freq();
        test_div();
        test_frame();
        test_saturate();
        test_freq_change();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
